elastic_pipe_stage: RTL and testbench

// Parametrised successor to the fixed-field pipeline registers between the IF/ID/EX/MEM/WB stages.
// It is a DEPTH-deep chain of WIDTH-bit pipeline slots.
// - Each slot carries a valid bit and uses valid/ready backpressure instead of a global stall.
// - Each slot can be squashed on its own via a flush mask (branch/jump kill of younger slots).
// - A global hold freezes the chain (cache-miss wait).

---
 rtl/elastic_pipe_stage_if.sv | 28 ++
 rtl/elastic_pipe_stage.sv | 66 ++++++
 tb/tb_elastic_pipe_stage.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elastic_pipe_stage_if.sv
// Bundle of handshake, control and status signals around one elastic_pipe_stage.
// A transfer happens on a rising edge where valid and ready are both 1; valid never waits on ready.
interface elastic_pipe_stage_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [DEPTH-1:0] flush;
   logic             hold;
   logic [OCC_W-1:0] occupancy;

   modport slave (
      input  in_valid, in_data, out_ready, flush, hold,
      output in_ready, out_valid, out_data, occupancy
   );

   modport master (
      output in_valid, in_data, out_ready, flush, hold,
      input  in_ready, out_valid, out_data, occupancy
   );
endinterface

// File: rtl/elastic_pipe_stage.sv
// DEPTH-deep chain of valid-tagged pipeline slots with valid/ready backpressure,
// per-slot flush and a global hold. Slot 0 is youngest, slot DEPTH-1 is the head.
module elastic_pipe_stage #(
   parameter int               WIDTH  = 32,
   parameter int               DEPTH  = 1,
   parameter logic [WIDTH-1:0] BUBBLE = '0
) (
   input logic                 CLK,
   input logic                 RST,
   elastic_pipe_stage_if.slave bus
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] r_valid;
   logic [WIDTH-1:0] r_data [DEPTH];
   logic [DEPTH:0]   w_rdy;
   logic [DEPTH-1:0] w_src_valid;
   logic [WIDTH-1:0] w_src_data [DEPTH];
   logic [OCC_W-1:0] w_occ;

   // A slot may load when it or any older slot is empty, or the head drains;
   // written flat instead of as a ripple so no bit depends on another bit of w_rdy.
   assign w_rdy[DEPTH] = bus.out_ready;
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rdy
      assign w_rdy[gi] = bus.out_ready | ~(&r_valid[DEPTH-1:gi]);
   end

   // A flushed slot hands a bubble to its successor rather than its old payload.
   assign w_src_valid[0] = bus.in_valid;
   assign w_src_data[0]  = bus.in_data;
   for (genvar gi = 1; gi < DEPTH; gi++) begin : g_src
      assign w_src_valid[gi] = r_valid[gi-1] & ~bus.flush[gi-1];
      assign w_src_data[gi]  = r_data[gi-1];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= BUBBLE;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (bus.flush[i]) begin
               r_valid[i] <= 1'b0;
               r_data[i]  <= BUBBLE;
            end else if (!bus.hold && w_rdy[i]) begin
               r_valid[i] <= w_src_valid[i];
               r_data[i]  <= w_src_valid[i] ? w_src_data[i] : BUBBLE;
            end
         end
      end
   end

   always_comb begin
      w_occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_occ = w_occ + OCC_W'(r_valid[i]);
      end
   end

   assign bus.in_ready  = w_rdy[0] & ~bus.hold;
   assign bus.out_valid = r_valid[DEPTH-1] & ~bus.flush[DEPTH-1] & ~bus.hold;
   assign bus.out_data  = r_data[DEPTH-1];
   assign bus.occupancy = w_occ;
endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Self-checking bench for elastic_pipe_stage with WIDTH=8, DEPTH=3, BUBBLE=8'h00.
module tb_elastic_pipe_stage;
   localparam int W = 8;
   localparam int D = 3;

   logic clk = 1'b0;
   logic rst;

   elastic_pipe_stage_if #(.WIDTH(W), .DEPTH(D)) bus ();

   elastic_pipe_stage #(.WIDTH(W), .DEPTH(D), .BUBBLE(8'h00)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [W-1:0] exp_q[$];
   int tests_run = 0;
   int fails     = 0;
   int n_pops    = 0;

   // Scoreboard: accepted items are queued, emitted items are popped and compared.
   always @(negedge clk) begin
      logic [W-1:0] exp;
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) begin
            tests_run++;
            n_pops++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL sb_unexpected: got %h, required no output", bus.out_data);
            end else begin
               exp = exp_q.pop_front();
               if (bus.out_data !== exp) begin
                  fails++;
                  $display("FAIL sb_data: got %h, required %h", bus.out_data, exp);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      bus.flush     = '0;
      bus.hold      = 1'b0;
   endtask

   task automatic push_item(input logic [W-1:0] d);
      bit acc = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      for (int n = 0; n < 8 && !acc; n++) begin
         @(negedge clk);
         acc = bus.in_ready;
         cyc();
      end
      bus.in_valid = 1'b0;
      tests_run++;
      if (!acc) begin
         fails++;
         $display("FAIL push_timeout: item %h got in_ready=0, required 1", d);
      end
   endtask

   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.flush     = '0;
      bus.hold      = 1'b0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (bus.occupancy == 0) break;
         cyc();
      end
      tests_run += 2;
      if (bus.occupancy !== 2'd0) begin
         fails++;
         $display("FAIL drain_occ: got %0d, required 0", bus.occupancy);
      end
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain_lost: got %0d items pending, required 0", exp_q.size());
      end
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h5A;
      bus.out_ready = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      set_idle();
      @(negedge clk);
      tests_run += 4;
      if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
      if (bus.out_data !== 8'h00) begin fails++; $display("FAIL rst_out_data: got %h, required 00", bus.out_data); end
      if (bus.occupancy !== 2'd0) begin fails++; $display("FAIL rst_occ: got %0d, required 0", bus.occupancy); end
      if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b, required 1", bus.in_ready); end
      cyc();
   endtask

   task automatic test_stream();
      logic [W-1:0] items [3];
      int lat = -1, peak = 0, run = 0;
      items[0] = 8'hA1; items[1] = 8'hA2; items[2] = 8'hA3;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         bus.in_valid = (c < 3);
         bus.in_data  = (c < 3) ? items[c] : 8'h00;
         @(negedge clk);
         if (int'(bus.occupancy) > peak) peak = int'(bus.occupancy);
         if (bus.out_valid) begin
            if (lat < 0) lat = c;
            run++;
         end
         cyc();
      end
      tests_run += 3;
      if (lat != 3) begin fails++; $display("FAIL stream_latency: got %0d, required 3", lat); end
      if (run != 3) begin fails++; $display("FAIL stream_count: got %0d, required 3", run); end
      if (peak != 3) begin fails++; $display("FAIL stream_peak_occ: got %0d, required 3", peak); end
      drain();
   endtask

   task automatic test_backpressure();
      logic [W-1:0] items [4];
      int k = 0;
      items[0] = 8'hB1; items[1] = 8'hB2; items[2] = 8'hB3; items[3] = 8'hB4;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int c = 0; c < 6; c++) begin
         bus.in_data = items[k];
         @(negedge clk);
         if (bus.in_ready && k < 3) k++;
         cyc();
      end
      @(negedge clk);
      tests_run += 3;
      if (k != 3) begin fails++; $display("FAIL bp_accepted: got %0d, required 3", k); end
      if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b, required 0", bus.in_ready); end
      if (bus.occupancy !== 2'd3) begin fails++; $display("FAIL bp_occ: got %0d, required 3", bus.occupancy); end
      cyc();
      bus.out_ready = 1'b1;
      bus.in_data   = items[3];
      @(negedge clk);
      tests_run += 2;
      if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_fill_ready: got %b, required 1", bus.in_ready); end
      if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_pop_valid: got %b, required 1", bus.out_valid); end
      cyc();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      @(negedge clk);
      tests_run += 2;
      if (bus.occupancy !== 2'd3) begin fails++; $display("FAIL bp_occ_after: got %0d, required 3", bus.occupancy); end
      if (bus.out_data !== 8'hB2) begin fails++; $display("FAIL bp_head_after: got %h, required B2", bus.out_data); end
      cyc();
      drain();
   endtask

   task automatic test_flush_mask();
      bus.out_ready = 1'b0;
      push_item(8'h33);
      push_item(8'h22);
      push_item(8'h11);
      bus.flush = 3'b011;
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL fm_head_kept: got %b, required 1", bus.out_valid); end
      cyc();
      bus.flush = '0;
      exp_q.delete();
      exp_q.push_back(8'h33);
      @(negedge clk);
      tests_run += 4;
      if (bus.occupancy !== 2'd1) begin fails++; $display("FAIL fm_occ: got %0d, required 1", bus.occupancy); end
      if (bus.out_data !== 8'h33) begin fails++; $display("FAIL fm_out_data: got %h, required 33", bus.out_data); end
      if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL fm_out_valid: got %b, required 1", bus.out_valid); end
      if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL fm_in_ready: got %b, required 1", bus.in_ready); end
      cyc();
      drain();
   endtask

   task automatic test_head_flush();
      int first = -1;
      bus.out_ready = 1'b0;
      push_item(8'h44);
      cyc();
      cyc();
      @(negedge clk);
      tests_run += 2;
      if (bus.occupancy !== 2'd1) begin fails++; $display("FAIL hf_setup_occ: got %0d, required 1", bus.occupancy); end
      if (bus.out_data !== 8'h44) begin fails++; $display("FAIL hf_setup_head: got %h, required 44", bus.out_data); end
      cyc();
      bus.out_ready = 1'b1;
      bus.flush     = 3'b100;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h55;
      @(negedge clk);
      tests_run += 2;
      if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL hf_out_valid: got %b, required 0", bus.out_valid); end
      if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL hf_in_ready: got %b, required 1", bus.in_ready); end
      cyc();
      void'(exp_q.pop_front());
      bus.flush    = '0;
      bus.in_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (bus.out_valid && first < 0) first = c;
         cyc();
      end
      tests_run++;
      if (first != 3) begin fails++; $display("FAIL hf_next_item: got cycle %0d, required 3", first); end
      drain();
   endtask

   task automatic test_hold();
      logic [W-1:0] items [6];
      int k = 0, occ_ref = 0, pops0;
      for (int i = 0; i < 6; i++) items[i] = 8'hC1 + 8'(i);
      pops0 = n_pops;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         bus.in_valid = (k < 6);
         bus.in_data  = (k < 6) ? items[k] : 8'h00;
         bus.hold     = (c >= 3 && c < 7);
         @(negedge clk);
         if (bus.hold) begin
            tests_run += 2;
            if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready c%0d: got %b, required 0", c, bus.in_ready); end
            if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL hold_out_valid c%0d: got %b, required 0", c, bus.out_valid); end
            if (c == 3) occ_ref = int'(bus.occupancy);
            else begin
               tests_run++;
               if (int'(bus.occupancy) != occ_ref) begin fails++; $display("FAIL hold_occ c%0d: got %0d, required %0d", c, bus.occupancy, occ_ref); end
            end
         end
         if (bus.in_valid && bus.in_ready) k++;
         if (k == 6 && !bus.in_valid && bus.occupancy == 0) break;
         cyc();
      end
      cyc();
      bus.hold = 1'b0;
      tests_run += 3;
      if (occ_ref != 3) begin fails++; $display("FAIL hold_occ_level: got %0d, required 3", occ_ref); end
      if (k != 6) begin fails++; $display("FAIL hold_accepted: got %0d, required 6", k); end
      if (n_pops - pops0 != 6) begin fails++; $display("FAIL hold_emitted: got %0d, required 6", n_pops - pops0); end
      drain();
   endtask

   task automatic test_midstream_reset();
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         bus.in_data = 8'hD1 + 8'(c);
         cyc();
      end
      rst = 1'b1;
      bus.in_data = 8'hD4;
      @(negedge clk);
      tests_run++;
      if (bus.occupancy !== 2'd3) begin fails++; $display("FAIL mr_full: got %0d, required 3", bus.occupancy); end
      cyc();
      rst = 1'b0;
      exp_q.delete();
      bus.in_valid = 1'b0;
      @(negedge clk);
      tests_run += 3;
      if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mr_out_valid: got %b, required 0", bus.out_valid); end
      if (bus.out_data !== 8'h00) begin fails++; $display("FAIL mr_out_data: got %h, required 00", bus.out_data); end
      if (bus.occupancy !== 2'd0) begin fails++; $display("FAIL mr_occ: got %0d, required 0", bus.occupancy); end
      cyc();
      cyc();
      cyc();
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mr_ghost: got %b, required 0", bus.out_valid); end
      cyc();
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_data   = 8'($urandom_range(0, 255));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.hold      = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         tests_run++;
         if (bus.occupancy > 2'd3) begin fails++; $display("FAIL rnd_occ c%0d: got %0d, required <=3", c, bus.occupancy); end
         cyc();
      end
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      set_idle();
      test_reset();
      test_stream();
      test_backpressure();
      test_flush_mask();
      test_head_flush();
      test_hold();
      test_midstream_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
